// File: rtl/rom_fifo_sequencer_pkg.sv
// Shared types and widths for the ROM-to-FIFO sequencer slice.
package plis_pkg;
   localparam int PLIS_AW = 11;
   localparam int PLIS_DW = 6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      PUSH  = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/rom_fifo_sequencer_if.sv
// Control, ROM and FIFO-write signals of the sequencer bundled into one interface.
interface rom_fifo_sequencer_if
   import plis_pkg::*;
#(
   parameter int AW = PLIS_AW,
   parameter int DW = PLIS_DW
);
   // start is a 1-cycle request, honoured only while busy is low; fifo_wrreq
   // transfers fifo_data on every high cycle and is only raised after a cycle
   // with fifo_wrfull low, so fifo_wrfull acts as the FIFO's inverted ready.
   logic          start;
   logic          abort;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] length;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_q;
   logic [DW-1:0] fifo_data;
   logic          fifo_wrreq;
   logic          fifo_wrfull;
   logic          busy;
   logic          done;

   modport master (
      input  start, abort, base_addr, length, rom_q, fifo_wrfull,
      output rom_addr, fifo_data, fifo_wrreq, busy, done
   );

   modport slave (
      output start, abort, base_addr, length, rom_q, fifo_wrfull,
      input  rom_addr, fifo_data, fifo_wrreq, busy, done
   );
endinterface

// File: rtl/rom_fifo_sequencer_seq_lat_timer.sv
// Loadable down-counter that spaces ROM_LAT cycles between address and data.
module seq_lat_timer #(
   parameter int ROM_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);
   localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   logic [CW-1:0] r_cnt;

   // Loaded with ROM_LAT-1 so the zero flag marks the last wait cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CW'(ROM_LAT - 1);
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/rom_fifo_sequencer.sv
// Reads a burst of ROM words and pushes them into a FIFO, honouring FIFO full.
// Optional PLIS_SEQ_LOOP_EN: restart the burst from the live inputs after each pass.
module rom_fifo_sequencer
   import plis_pkg::*;
#(
   parameter int AW      = PLIS_AW,
   parameter int DW      = PLIS_DW,
   parameter int ROM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   rom_fifo_sequencer_if.master bus,
   output state_t               o_dbg_state
);
   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic [AW-1:0] r_rem, w_rem_nxt;
   logic [AW-1:0] r_rom_addr, w_rom_addr_nxt;
   logic [DW-1:0] r_fifo_data, w_fifo_data_nxt;
   logic          r_wrreq, w_wrreq_nxt;
   logic          r_done, w_done_nxt;
   logic          r_busy;
   logic          w_tmr_load, w_tmr_dec, w_tmr_zero;

   seq_lat_timer #(.ROM_LAT(ROM_LAT)) u_lat_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_tmr_load),
      .i_dec  (w_tmr_dec),
      .o_zero (w_tmr_zero)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_rem_nxt       = r_rem;
      w_rom_addr_nxt  = r_rom_addr;
      w_fifo_data_nxt = r_fifo_data;
      w_wrreq_nxt     = 1'b0;
      w_done_nxt      = 1'b0;
      w_tmr_load      = 1'b0;
      w_tmr_dec       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_addr_nxt  = bus.base_addr;
               w_rem_nxt   = bus.length;
               w_state_nxt = (bus.length == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            w_rom_addr_nxt = r_addr;
            w_tmr_load     = 1'b1;
            w_state_nxt    = WAIT;
         end
         WAIT: begin
            if (w_tmr_zero) w_state_nxt = PUSH;
            else            w_tmr_dec   = 1'b1;
         end
         PUSH: begin
            // rom_addr is held through a stall, so rom_q stays valid here.
            if (!bus.fifo_wrfull) begin
               w_wrreq_nxt     = 1'b1;
               w_fifo_data_nxt = bus.rom_q;
               w_rem_nxt       = r_rem - AW'(1);
               w_addr_nxt      = r_addr + AW'(1);
               if (r_rem == AW'(1)) begin
`ifdef PLIS_SEQ_LOOP_EN
                  w_addr_nxt = bus.base_addr;
                  w_rem_nxt  = bus.length;
                  if (bus.length == '0) begin
                     w_state_nxt = DONE;
                  end else begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = FETCH;
                  end
`else
                  w_state_nxt = DONE;
`endif
               end else begin
                  w_state_nxt = FETCH;
               end
            end
         end
         DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      // abort also suppresses a write or done decided in this same cycle.
      if (bus.abort) begin
         w_state_nxt = IDLE;
         w_wrreq_nxt = 1'b0;
         w_done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_rem       <= '0;
         r_rom_addr  <= '0;
         r_fifo_data <= '0;
         r_wrreq     <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_rem       <= w_rem_nxt;
         r_rom_addr  <= w_rom_addr_nxt;
         r_fifo_data <= w_fifo_data_nxt;
         r_wrreq     <= w_wrreq_nxt;
         r_done      <= w_done_nxt;
         r_busy      <= (w_state_nxt != IDLE);
      end
   end

   assign bus.rom_addr   = r_rom_addr;
   assign bus.fifo_data  = r_fifo_data;
   assign bus.fifo_wrreq = r_wrreq;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_rom_fifo_sequencer.sv
// Directed bench for rom_fifo_sequencer with a 1-cycle-latency ROM model.
module tb_rom_fifo_sequencer;
   import plis_pkg::*;

   localparam int AW = PLIS_AW;
   localparam int DW = PLIS_DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rom_fifo_sequencer_if #(.AW(AW), .DW(DW)) bus ();
   state_t dbg_state;

   rom_fifo_sequencer #(.AW(AW), .DW(DW), .ROM_LAT(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ROM contents: low 6 address bits plus twice the upper 5 bits, mod 64.
   always @(posedge clk) bus.rom_q <= bus.rom_addr[5:0] + {bus.rom_addr[10:6], 1'b0};

   // ---------------- scoreboard / monitor ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] got_data[$];
   logic [AW-1:0] got_addr[$];
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] exp_a[$];
   int   done_cnt = 0;
   int   full_viol = 0;
   int   cyc = 0;
   int   last_wr_cyc = 0;
   int   last_done_cyc = 0;
   logic busy_at_done = 1'b0;
   logic prev_full = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.fifo_wrreq === 1'b1) begin
            got_data.push_back(bus.fifo_data);
            got_addr.push_back(bus.rom_addr);
            last_wr_cyc = cyc;
            if (prev_full) full_viol++;
         end
         if (bus.done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            busy_at_done  = bus.busy;
         end
      end
      prev_full = bus.fifo_wrfull;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_data.delete();
      got_addr.delete();
      done_cnt  = 0;
      full_viol = 0;
   endtask

   task automatic pulse_start(input logic [AW-1:0] base, input logic [AW-1:0] len);
      bus.base_addr = base;
      bus.length    = len;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && done_cnt < target; i++) tick();
      n_checks++;
      if (done_cnt < target) begin
         n_fail++;
         $display("FAIL %s_timeout: done_cnt=%0d required=%0d", tag, done_cnt, target);
      end
   endtask

   task automatic check_words(input string tag);
      logic [DW-1:0] g;
      logic [AW-1:0] ga;
      n_checks++;
      if (got_data.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL %s_count: got %0d words, required %0d", tag, got_data.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_data.size()) ? got_data[i] : 'x;
         n_checks++;
         if (g !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s_data[%0d]: got %h required %h", tag, i, g, exp_q[i]);
         end
      end
      for (int i = 0; i < exp_a.size(); i++) begin
         ga = (i < got_addr.size()) ? got_addr[i] : 'x;
         n_checks++;
         if (ga !== exp_a[i]) begin
            n_fail++;
            $display("FAIL %s_addr[%0d]: got %h required %h", tag, i, ga, exp_a[i]);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
      n_checks++; if (bus.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL rst_wrreq: got %b required 0", bus.fifo_wrreq); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", bus.done); end
      n_checks++; if (bus.rom_addr !== 11'h000) begin n_fail++; $display("FAIL rst_rom_addr: got %h required 000", bus.rom_addr); end
      n_checks++; if (bus.fifo_data !== 6'h00) begin n_fail++; $display("FAIL rst_fifo_data: got %h required 00", bus.fifo_data); end

      // reset in the middle of a burst
      clear_mon();
      pulse_start(11'h010, 11'd4);
      repeat (3) tick();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", bus.busy); end
      n_checks++; if (bus.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL midrst_wrreq: got %b required 0", bus.fifo_wrreq); end
      n_checks++; if (bus.rom_addr !== 11'h000) begin n_fail++; $display("FAIL midrst_rom_addr: got %h required 000", bus.rom_addr); end
      n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d required IDLE", dbg_state); end
      clear_mon();
      repeat (10) tick();
      n_checks++; if (got_data.size() !== 0) begin n_fail++; $display("FAIL midrst_writes: got %0d required 0", got_data.size()); end
      n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midrst_done: got %0d required 0", done_cnt); end
   endtask

   task automatic test_basic();
      clear_mon();
      pulse_start(11'h010, 11'd4);
      wait_done(1, 100, "basic");
      repeat (2) tick();
      exp_q = '{6'h10, 6'h11, 6'h12, 6'h13};
      exp_a = '{11'h010, 11'h011, 11'h012, 11'h013};
      check_words("basic");
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d required 1", done_cnt); end
      n_checks++; if (last_done_cyc !== last_wr_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing: done at %0d required %0d", last_done_cyc, last_wr_cyc + 1); end
      n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b required 0", bus.busy); end
   endtask

   task automatic test_backpressure();
      clear_mon();
      pulse_start(11'h020, 11'd3);
      repeat (5) tick();                // second PUSH cycle
      bus.fifo_wrfull = 1'b1;
      repeat (3) tick();
      n_checks++; if (dbg_state !== PUSH) begin n_fail++; $display("FAIL bp_stall_state: got %0d required PUSH", dbg_state); end
      n_checks++; if (bus.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL bp_stall_wrreq: got %b required 0", bus.fifo_wrreq); end
      n_checks++; if (got_data.size() !== 1) begin n_fail++; $display("FAIL bp_stall_count: got %0d required 1", got_data.size()); end
      repeat (2) tick();
      bus.fifo_wrfull = 1'b0;
      wait_done(1, 100, "bp");
      repeat (2) tick();
      exp_q = '{6'h20, 6'h21, 6'h22};
      exp_a = '{11'h020, 11'h021, 11'h022};
      check_words("bp");
      n_checks++; if (full_viol !== 0) begin n_fail++; $display("FAIL bp_wr_while_full: got %0d required 0", full_viol); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d required 1", done_cnt); end
   endtask

   task automatic test_wrap();
      clear_mon();
      pulse_start(11'h7FE, 11'd4);
      wait_done(1, 100, "wrap");
      repeat (2) tick();
      exp_q = '{6'h3C, 6'h3D, 6'h00, 6'h01};
      exp_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
      check_words("wrap");
   endtask

   task automatic test_edge();
      // zero length
      clear_mon();
      pulse_start(11'h100, 11'd0);
      tick();
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b required 1", bus.done); end
      repeat (4) tick();
      n_checks++; if (got_data.size() !== 0) begin n_fail++; $display("FAIL len0_writes: got %0d required 0", got_data.size()); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL len0_done_cnt: got %0d required 1", done_cnt); end

      // start while busy is dropped
      clear_mon();
      pulse_start(11'h010, 11'd2);
      repeat (2) tick();
      pulse_start(11'h300, 11'd5);
      wait_done(1, 100, "busy_start");
      repeat (10) tick();
      exp_q = '{6'h10, 6'h11};
      exp_a = '{11'h010, 11'h011};
      check_words("busy_start");
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_queued: busy %b required 0", bus.busy); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_done: got %0d required 1", done_cnt); end

      // abort in WAIT
      clear_mon();
      pulse_start(11'h010, 11'd3);
      tick();
      n_checks++; if (dbg_state !== WAIT) begin n_fail++; $display("FAIL abort_pre_state: got %0d required WAIT", dbg_state); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d required IDLE", dbg_state); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", bus.busy); end
      repeat (10) tick();
      n_checks++; if (got_data.size() !== 0) begin n_fail++; $display("FAIL abort_writes: got %0d required 0", got_data.size()); end
      n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d required 0", done_cnt); end

      // start and abort together
      clear_mon();
      bus.abort = 1'b1;
      pulse_start(11'h010, 11'd3);
      bus.abort = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b required 0", bus.busy); end
      n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL start_abort_state: got %0d required IDLE", dbg_state); end
      repeat (10) tick();
      n_checks++; if (got_data.size() !== 0) begin n_fail++; $display("FAIL start_abort_writes: got %0d required 0", got_data.size()); end
      n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL start_abort_done: got %0d required 0", done_cnt); end
   endtask

`ifdef PLIS_SEQ_LOOP_EN
   task automatic test_loop();
      int n_wr;
      int n_done;
      clear_mon();
      pulse_start(11'h005, 11'd2);
      for (int i = 0; i < 200 && got_data.size() < 5; i++) tick();
      n_checks++; if (got_data.size() < 5) begin n_fail++; $display("FAIL loop_timeout: got %0d words required 5", got_data.size()); end
      exp_q = '{6'h05, 6'h06, 6'h05, 6'h06, 6'h05};
      exp_a = '{11'h005, 11'h006, 11'h005, 11'h006, 11'h005};
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_addr[i] !== exp_a[i]) begin
            n_fail++;
            $display("FAIL loop_word[%0d]: got %h required %h", i,
                     (i < got_data.size()) ? got_data[i] : 6'h00, exp_q[i]);
         end
      end
      n_checks++; if (done_cnt !== 2) begin n_fail++; $display("FAIL loop_done_cnt: got %0d required 2", done_cnt); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      n_wr   = got_data.size();
      n_done = done_cnt;
      repeat (10) tick();
      n_checks++; if (got_data.size() !== n_wr) begin n_fail++; $display("FAIL loop_abort_writes: got %0d required %0d", got_data.size(), n_wr); end
      n_checks++; if (done_cnt !== n_done) begin n_fail++; $display("FAIL loop_abort_done: got %0d required %0d", done_cnt, n_done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL loop_abort_busy: got %b required 0", bus.busy); end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.base_addr   = '0;
      bus.length      = '0;
      bus.fifo_wrfull = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_edge();
`ifdef PLIS_SEQ_LOOP_EN
      test_loop();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
